trace_port_tx: RTL and testbench

- Trace-port transmitter: serializes a byte stream onto a 1/2/4-bit parallel trace port, clocked by trace_clk.
- Emits trace sync frames (full sync FF FF FF 7F, bytes LSB-first) at start-up, on trace width change, periodically, and as idle filler.
- Drives the trace capture front-end in loopback and simulation benches. Its bit ordering and sync framing are exactly what the capture side's sync detector and sync filter expect.

---
 rtl/trace_port_tx.sv | 242 ++++++++++++++++++++++++
 tb/tb_trace_port_tx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/trace_port_tx.sv
// ---------------------------------------------------------------------------
// trace_port_tx
//
// Trace-port transmitter. Serializes a byte stream onto a 1/2/4-bit trace
// port clocked by trace_clk. Bytes go out LSB-first. Full sync frames
// (FF FF FF 7F) are sent:
//   - after reset and after a trace width change (pINIT_SYNC frames),
//   - periodically, every I_sync_period accepted data bytes,
//   - on request via I_force_sync,
//   - as idle filler when no data is offered.
//
// Optional build macro: TRACE_TX_HALF_SYNC_EN
//   defined   - idle filler uses half-sync frames (FF 7F); all other syncs
//               remain full frames.
//   undefined - idle filler uses full sync frames.
//
// Parameters:
//   pINIT_SYNC    : number of full sync frames in the start-up burst (1..15)
//   pPERIOD_WIDTH : width of the periodic-sync byte counter
//
// Ports:
//   trace_clk      in   sole clock
//   reset          in   synchronous, active-high
//   I_trace_width  in   3  port width 1/2/4; any other value means 4
//   I_sync_period  in   data bytes between forced full syncs, 0 = off
//   I_force_sync   in   pulse, requests one full sync frame
//   I_data         in   8  byte to transmit
//   I_data_valid   in   I_data is valid
//   O_data_ready   out  byte accepted this cycle when high with valid
//   trace_data     out  4  trace port pins, registered
//   O_synced       out  initial sync burst completed
//   O_sync_active  out  a sync or filler byte is on the pins
// ---------------------------------------------------------------------------
module trace_port_tx #(
    parameter int pINIT_SYNC    = 4,
    parameter int pPERIOD_WIDTH = 16
) (
    input  logic                     trace_clk,
    input  logic                     reset,
    input  logic [2:0]               I_trace_width,
    input  logic [pPERIOD_WIDTH-1:0] I_sync_period,
    input  logic                     I_force_sync,
    input  logic [7:0]               I_data,
    input  logic                     I_data_valid,
    output logic                     O_data_ready,
    output logic [3:0]               trace_data,
    output logic                     O_synced,
    output logic                     O_sync_active
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

`ifdef TRACE_TX_HALF_SYNC_EN
    localparam logic FILL_HALF = 1'b1;
`else
    localparam logic FILL_HALF = 1'b0;
`endif

    localparam logic [3:0]               INIT_LAST = 4'(pINIT_SYNC - 1);
    localparam logic [pPERIOD_WIDTH-1:0] PCNT_ONE  = 1;

    state_t                   state;
    logic [2:0]               width_q;
    logic                     first_q;        // forces a load cycle after reset / width change
    logic [2:0]               beat_q;
    logic [7:0]               byte_q;
    logic                     frame_active_q;
    logic [1:0]               frame_idx_q;    // index of the next frame byte to load
    logic                     frame_half_q;
    logic [3:0]               init_cnt_q;
    logic                     force_pend_q;
    logic                     period_pend_q;
    logic [pPERIOD_WIDTH-1:0] period_cnt_q;

    logic [2:0] width_eff;
    logic [2:0] last_beat;
    logic       width_change;
    logic       load;
    logic       period_hit;
    logic       sync_pending;
    logic [1:0] frame_last;

    logic [7:0] ld_byte;
    logic       ld_sync;
    logic       frame_end;
    logic       start_sync;
    logic       start_fill;

    // Pin slice of a byte for a given beat; unused pins drive 0.
    function automatic logic [3:0] beat_slice(input logic [7:0] b,
                                              input logic [2:0] idx,
                                              input logic [2:0] w);
        logic [3:0] r;
        case (w)
            3'd1:    r = {3'b000, b[idx]};
            3'd2:    r = {2'b00, b[{idx[1:0], 1'b0} +: 2]};
            default: r = idx[0] ? b[7:4] : b[3:0];
        endcase
        return r;
    endfunction

    always_comb begin
        case (width_q)
            3'd1:    width_eff = 3'd1;
            3'd2:    width_eff = 3'd2;
            default: width_eff = 3'd4;
        endcase
    end

    always_comb begin
        case (width_eff)
            3'd1:    last_beat = 3'd7;
            3'd2:    last_beat = 3'd3;
            default: last_beat = 3'd1;
        endcase
    end

    assign width_change = (I_trace_width != width_q);
    assign load         = first_q || (beat_q == last_beat);
    assign period_hit   = (I_sync_period != '0) && (period_cnt_q == I_sync_period);
    assign sync_pending = (state == ST_INIT) || force_pend_q || period_pend_q || period_hit;
    assign frame_last   = frame_half_q ? 2'd1 : 2'd3;

    // Ready is withheld on a width-change cycle: the byte would be aborted
    // at the same edge that accepts it.
    assign O_data_ready = load && (state == ST_RUN) && !frame_active_q &&
                          !sync_pending && !width_change;

    // Byte source for the current load cycle, highest priority first.
    always_comb begin
        ld_byte    = 8'hFF;
        ld_sync    = 1'b1;
        frame_end  = 1'b0;
        start_sync = 1'b0;
        start_fill = 1'b0;
        if (frame_active_q) begin
            frame_end = (frame_idx_q == frame_last);
            ld_byte   = frame_end ? 8'h7F : 8'hFF;
        end else if (sync_pending) begin
            start_sync = 1'b1;
        end else if (I_data_valid) begin
            ld_byte = I_data;
            ld_sync = 1'b0;
        end else begin
            start_fill = 1'b1;
        end
    end

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state          <= ST_INIT;
            width_q        <= I_trace_width;
            first_q        <= 1'b1;
            beat_q         <= '0;
            byte_q         <= '0;
            frame_active_q <= 1'b0;
            frame_idx_q    <= '0;
            frame_half_q   <= 1'b0;
            init_cnt_q     <= '0;
            force_pend_q   <= 1'b0;
            period_pend_q  <= 1'b0;
            period_cnt_q   <= '0;
            trace_data     <= 4'h0;
            O_synced       <= 1'b0;
            O_sync_active  <= 1'b0;
        end else if (width_change) begin
            // Abort the byte in flight and restart the sync burst at the
            // new width; the next cycle is a load cycle.
            state          <= ST_INIT;
            width_q        <= I_trace_width;
            first_q        <= 1'b1;
            beat_q         <= '0;
            frame_active_q <= 1'b0;
            frame_idx_q    <= '0;
            frame_half_q   <= 1'b0;
            init_cnt_q     <= '0;
            force_pend_q   <= force_pend_q || I_force_sync;
            period_pend_q  <= 1'b0;
            period_cnt_q   <= '0;
            trace_data     <= 4'h0;
            O_synced       <= 1'b0;
            O_sync_active  <= 1'b0;
        end else begin
            if (I_force_sync) begin
                force_pend_q <= 1'b1;
            end

            if (period_hit) begin
                period_pend_q <= 1'b1;
                period_cnt_q  <= '0;
            end else if (O_data_ready && I_data_valid) begin
                period_cnt_q <= period_cnt_q + PCNT_ONE;
            end

            if (load) begin
                first_q       <= 1'b0;
                beat_q        <= '0;
                byte_q        <= ld_byte;
                trace_data    <= beat_slice(ld_byte, 3'd0, width_eff);
                O_sync_active <= ld_sync;

                if (frame_active_q) begin
                    frame_idx_q <= frame_idx_q + 2'd1;
                    if (frame_end) begin
                        frame_active_q <= 1'b0;
                        if (state == ST_INIT) begin
                            if (init_cnt_q == INIT_LAST) begin
                                state    <= ST_RUN;
                                O_synced <= 1'b1;
                            end else begin
                                init_cnt_q <= init_cnt_q + 4'd1;
                            end
                        end
                    end
                end

                // A starting sync frame serves every pending request at
                // once, including a force pulse arriving on this edge.
                if (start_sync) begin
                    frame_active_q <= 1'b1;
                    frame_idx_q    <= 2'd1;
                    frame_half_q   <= 1'b0;
                    force_pend_q   <= 1'b0;
                    period_pend_q  <= 1'b0;
                end

                if (start_fill) begin
                    frame_active_q <= 1'b1;
                    frame_idx_q    <= 2'd1;
                    frame_half_q   <= FILL_HALF;
                end
            end else begin
                beat_q     <= beat_q + 3'd1;
                trace_data <= beat_slice(byte_q, beat_q + 3'd1, width_eff);
            end
        end
    end

endmodule

// File: tb/tb_trace_port_tx.sv
module tb_trace_port_tx;

    logic        trace_clk = 1'b0;
    logic        reset;
    logic [2:0]  I_trace_width;
    logic [15:0] I_sync_period;
    logic        I_force_sync;
    logic [7:0]  I_data;
    logic        I_data_valid;
    logic        O_data_ready;
    logic [3:0]  trace_data;
    logic        O_synced;
    logic        O_sync_active;

    int tests = 0;
    int fails = 0;

    always #5 trace_clk = ~trace_clk;

    trace_port_tx #(
        .pINIT_SYNC   (2),
        .pPERIOD_WIDTH(16)
    ) dut (
        .trace_clk    (trace_clk),
        .reset        (reset),
        .I_trace_width(I_trace_width),
        .I_sync_period(I_sync_period),
        .I_force_sync (I_force_sync),
        .I_data       (I_data),
        .I_data_valid (I_data_valid),
        .O_data_ready (O_data_ready),
        .trace_data   (trace_data),
        .O_synced     (O_synced),
        .O_sync_active(O_sync_active)
    );

    typedef struct {
        logic [2:0]  w;
        logic [7:0]  d;
        int          nb;
        logic [31:0] exp;   // nibble i = pins on beat i
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [2:0] w, input logic [15:0] per);
        @(negedge trace_clk);
        reset         = 1'b1;
        I_trace_width = w;
        I_sync_period = per;
        I_force_sync  = 1'b0;
        I_data_valid  = 1'b0;
        I_data        = 8'h00;
        repeat (3) @(negedge trace_clk);
        check("reset trace_data", trace_data, 0);
        check("reset ready", O_data_ready, 0);
        check("reset synced", O_synced, 0);
        check("reset sync_active", O_sync_active, 0);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!O_data_ready && n < 300) begin
            @(negedge trace_clk);
            n++;
        end
        check(name, O_data_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  exp_seq[14];
        logic [7:0]  fill_exp;
        logic [3:0]  lo, hi, e;
        logic        rdy;
        int          nxt, n;
        logic [7:0]  fb;

        reset = 1'b1; I_trace_width = 3'd4; I_sync_period = '0;
        I_force_sync = 1'b0; I_data = '0; I_data_valid = 1'b0;

        vecs[0] = '{3'd4, 8'hA5, 2, 32'h000000A5};
        vecs[1] = '{3'd4, 8'h3C, 2, 32'h0000003C};
        vecs[2] = '{3'd2, 8'hA5, 4, 32'h00002211};
        vecs[3] = '{3'd1, 8'hA5, 8, 32'h10100101};
        vecs[4] = '{3'd2, 8'h3C, 4, 32'h00000330};
        vecs[5] = '{3'd1, 8'h81, 8, 32'h10000001};
        vecs[6] = '{3'd2, 8'hE4, 4, 32'h00003210};
        vecs[7] = '{3'd1, 8'h3C, 8, 32'h00111100};
        vecs[8] = '{3'd0, 8'h5A, 2, 32'h0000005A};
        vecs[9] = '{3'd7, 8'hC3, 2, 32'h000000C3};

        // Start-up burst at width 4: two full frames.
        do_reset(3'd4, 16'd0);
        for (int s = 0; s < 16; s++) begin
            @(negedge trace_clk);
            check("init pins", trace_data, (s % 8 == 7) ? 4'h7 : 4'hF);
            check("init sync_active", O_sync_active, 1);
            check("init synced", O_synced, (s >= 14) ? 1 : 0);
            check("init ready", O_data_ready, (s == 15) ? 1 : 0);
        end

        // Back-to-back A5, 3C, then idle filler.
        I_data = 8'hA5; I_data_valid = 1'b1;
        @(negedge trace_clk);
        check("stream b0", trace_data, 4'h5);
        check("stream sa0", O_sync_active, 0);
        I_data = 8'h3C;
        @(negedge trace_clk);
        check("stream b1", trace_data, 4'hA);
        check("stream ready2", O_data_ready, 1);
        @(negedge trace_clk);
        check("stream b2", trace_data, 4'hC);
        check("stream sa2", O_sync_active, 0);
        I_data_valid = 1'b0;
        @(negedge trace_clk);
        check("stream b3", trace_data, 4'h3);
        for (int s = 0; s < 8; s++) begin
            @(negedge trace_clk);
`ifdef TRACE_TX_HALF_SYNC_EN
            e = (s % 4 == 3) ? 4'h7 : 4'hF;
`else
            e = (s == 7) ? 4'h7 : 4'hF;
`endif
            check("filler pins", trace_data, e);
            check("filler sync_active", O_sync_active, 1);
        end

        // Single-byte vectors at every width, including out-of-range codes.
        for (int i = 0; i < 10; i++) begin
            do_reset(vecs[i].w, 16'd0);
            wait_ready("vec ready");
            I_data = vecs[i].d; I_data_valid = 1'b1;
            @(posedge trace_clk); #1;
            I_data_valid = 1'b0;
            for (int b = 0; b < vecs[i].nb; b++) begin
                @(negedge trace_clk);
                check("vec pins", trace_data, vecs[i].exp[4*b +: 4]);
                check("vec sync_active", O_sync_active, 0);
            end
        end

        // Periodic sync every 3 bytes.
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'hFF, 8'h7F,
                    8'h04, 8'h05, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        do_reset(3'd4, 16'd3);
        wait_ready("period ready");
        nxt = 1; I_data = 8'h01; I_data_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            rdy = O_data_ready;
            check("period ready seq", rdy, (k <= 2 || (k >= 7 && k <= 9)) ? 1 : 0);
            @(posedge trace_clk); #1;
            if (rdy && I_data_valid) begin
                nxt++;
                if (nxt > 6) I_data_valid = 1'b0;
                else I_data = 8'(nxt);
            end
            @(negedge trace_clk); lo = trace_data;
            @(negedge trace_clk); hi = trace_data;
            check("period byte", {hi, lo}, exp_seq[k]);
        end

        // Two force pulses before the frame starts coalesce into one frame.
        do_reset(3'd2, 16'd0);
        wait_ready("force ready");
        I_data = 8'h11; I_data_valid = 1'b1;
        @(posedge trace_clk); #1;
        I_force_sync = 1'b1;
        @(posedge trace_clk); #1;
        I_force_sync = 1'b0;
        @(posedge trace_clk); #1;
        I_force_sync = 1'b1;
        @(posedge trace_clk); #1;
        I_force_sync = 1'b0;
        @(negedge trace_clk);
        check("force ready low", O_data_ready, 0);
        n = 0;
        do begin
            @(negedge trace_clk);
            n++;
            if (n == 1) check("force sync_active", O_sync_active, 1);
        end while (!O_data_ready && n < 100);
        check("force frame cycles", n, 16);
        I_data_valid = 1'b0;

        // Width change 4 -> 1 in the middle of a data byte.
        do_reset(3'd4, 16'd0);
        wait_ready("wchg ready");
        I_data = 8'hA5; I_data_valid = 1'b1;
        @(posedge trace_clk); #1;
        I_data_valid = 1'b0;
        I_trace_width = 3'd1;
        @(negedge trace_clk);
        check("wchg mid pins", trace_data, 4'h5);
        check("wchg mid synced", O_synced, 1);
        @(negedge trace_clk);
        check("wchg synced drop", O_synced, 0);
        check("wchg pins abort", trace_data, 0);
        for (int s = 0; s < 64; s++) begin
            @(negedge trace_clk);
            fb = ((s / 8) % 4 == 3) ? 8'h7F : 8'hFF;
            check("wchg pins", trace_data, {3'b000, fb[s % 8]});
            check("wchg synced", O_synced, (s >= 56) ? 1 : 0);
            check("wchg ready", O_data_ready, (s == 63) ? 1 : 0);
        end

        // Reset mid-byte: the partial byte is not resent.
        I_data = 8'h00; I_data_valid = 1'b1;
        @(posedge trace_clk); #1;
        I_data_valid = 1'b0;
        do_reset(3'd1, 16'd0);
        for (int s = 0; s < 8; s++) begin
            @(negedge trace_clk);
            check("rst mid pins", trace_data, 4'h1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
